nios_system_reset_seq: RTL and testbench
========================================

// Module: nios_system_reset_seq
// PURPOSE
//  Reset sequencer downstream of nios_system_pll. Holds PLL in reset, qualifies its locked output,
//  then releases memory-side (SDRAM ctrl) and CPU-side (Nios II) resets in order. On loss of lock
//  it re-runs the whole sequence. Runs on the free-running 50 MHz board clock (PLL refclk).
// PARAMETERS
//  PLL_RST_CYCLES      16     cycles pll_rst held high per attempt
//  LOCK_STABLE_CYCLES  1024   consecutive synchronized-locked cycles required before release
//  LOCK_TIMEOUT_CYCLES 65535  max cycles in WAIT_LOCK before re-resetting the PLL
//  STAGE_CYCLES        64     gap mem_reset_n release -> cpu_reset_n release; also soft-reset hold
//  SYNC_STAGES         2      flops in pll_locked synchronizer (>=2)
//  CNT_W               16     counter width; must hold max(all *_CYCLES)
// PORTS
//  clk             in   1  50 MHz board clock (PLL refclk), free-running
//  reset_n         in   1  async active-low reset; asserts all outputs immediately
//  pll_locked      in   1  PLL locked, asynchronous to clk
//  soft_reset_req  in   1  single-cycle request to re-reset mem+CPU without touching PLL
//  pll_rst         out  1  active-high reset to PLL rst
//  mem_reset_n     out  1  active-low reset, SDRAM controller domain
//  cpu_reset_n     out  1  active-low reset, Nios II/Avalon domain
//  seq_ready       out  1  1 while in RUN
//  lock_loss_cnt   out  8  [RESET_SEQ_STATUS_EN only] saturating count of lock losses
//  lock_timeout    out  1  [RESET_SEQ_STATUS_EN only] sticky: a WAIT_LOCK timeout occurred
// BEHAVIOUR
//  Reset (reset_n=0): state=PLL_RST, counters=0, pll_rst=1, mem_reset_n=0, cpu_reset_n=0,
//   seq_ready=0, lock_loss_cnt=0, lock_timeout=0. Outputs registered, decoded from next state
//   (change on the same edge the state is entered). locked_s = pll_locked after SYNC_STAGES flops.
//  PLL_RST:  pll_rst=1, mem/cpu reset asserted. Exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
//  WAIT_LOCK: pll_rst=0. stable_cnt increments while locked_s=1, clears on locked_s=0.
//   stable_cnt reaches LOCK_STABLE_CYCLES -> MEM_REL. Else timeout_cnt reaches LOCK_TIMEOUT_CYCLES
//   -> PLL_RST. Both same cycle: MEM_REL wins.
//  MEM_REL:  mem_reset_n=1, cpu_reset_n=0; STAGE_CYCLES cycles, then RUN.
//  RUN:      mem_reset_n=1, cpu_reset_n=1, seq_ready=1; stays until an event below.
//  SOFT_RST: mem/cpu reset asserted, pll_rst=0; STAGE_CYCLES cycles, then MEM_REL.
//  Lock loss: locked_s=0 in MEM_REL, RUN or SOFT_RST -> PLL_RST next edge, all resets asserted.
//  soft_reset_req=1 in RUN -> SOFT_RST; ignored in every other state. Lock loss beats soft reset.
//  Every state entry clears the stage counter; counters never wrap (compare, not overflow).
//  reset_n low mid-sequence: immediate async return to reset values; restart from PLL_RST.
// CONFIGURATION
//  `RESET_SEQ_STATUS_EN defined: lock_loss_cnt increments (saturates at 255) on each lock-loss
//   transition; lock_timeout sets on each WAIT_LOCK timeout, cleared only by reset_n.
//  Undefined: both ports and their logic are absent; sequencing is identical.
// STRUCTURE
//  Package nios_system_rst_pkg: state enum (PLL_RST, WAIT_LOCK, MEM_REL, RUN, SOFT_RST),
//   LOSS_CNT_W=8 constant.
//  Sub-module nios_system_sync_bit (SYNC_STAGES-deep, async-reset-to-0 bit synchronizer) for
//   pll_locked. FSM, counters and output registers stay in this module.
// TESTING (PLL_RST=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGE=4, SYNC=2)
//  Cold boot: reset_n rises, pll_locked=1 from cycle 6 -> pll_rst 1 for 4 cycles;
//   mem_reset_n rises 8 cycles after locked_s=1; cpu_reset_n and seq_ready rise 4 cycles later.
//  Glitchy lock: pll_locked 1 for 5 cycles, 0 for 1, then 1 -> stable count restarts; release
//   only after 8 unbroken cycles.
//  Timeout: pll_locked held 0 -> pll_rst re-pulses (4 cycles) every 36 cycles; lock_timeout=1.
//  Lock loss in RUN: drop pll_locked -> 2 cycles later (sync) all resets assert next edge,
//   pll_rst=1, lock_loss_cnt=1.
//  Soft reset: pulse soft_reset_req in RUN -> mem/cpu reset low for 4 cycles, mem_reset_n high
//   4 cycles before cpu_reset_n; pll_rst stays 0. Same pulse during MEM_REL -> ignored.
//  Async reset mid-MEM_REL: reset_n low -> all outputs at reset values with no clock edge.

Source files
------------

// File: rtl/nios_system_rst_pkg.sv
// Shared state encoding and constants for the nios_system reset sequencer.
// The lock-loss counter width and its saturating increment live here.
package nios_system_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        MEM_REL   = 3'd2,
        RUN       = 3'd3,
        SOFT_RST  = 3'd4
    } rst_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        logic [LOSS_CNT_W-1:0] r;
        if (v == {LOSS_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + LOSS_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_system_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, async-reset to 0.
module nios_system_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/nios_system_reset_seq.sv
// Reset sequencer: PLL reset, lock qualification, then ordered SDRAM / Nios II release.
// Optional status outputs (lock_loss_cnt, lock_timeout) are enabled by `RESET_SEQ_STATUS_EN.
module nios_system_reset_seq
    import nios_system_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int STAGE_CYCLES        = 64,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_reset_req,
    output logic                  pll_rst,
    output logic                  mem_reset_n,
    output logic                  cpu_reset_n,
    output logic                  seq_ready
`ifdef RESET_SEQ_STATUS_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic                  lock_timeout
`endif
);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);

    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic             locked_s;
    logic             lock_loss_s;
    logic             timeout_s;
    logic             pll_rst_q, mem_reset_n_q, cpu_reset_n_q, seq_ready_q;

    nios_system_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    // Next-state logic; every transition clears the stage and stable counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = '0;
        lock_loss_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // A qualified lock takes priority over a coincident timeout.
                if (locked_s && (stable_q == STABLE_LAST)) begin
                    state_d = MEM_REL;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    cnt_d     = '0;
                    timeout_s = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    stable_d = locked_s ? (stable_q + CNT_W'(1)) : '0;
                end
            end
            MEM_REL: begin
                if (!locked_s) begin
                    state_d     = PLL_RST;
                    cnt_d       = '0;
                    lock_loss_s = 1'b1;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d     = PLL_RST;
                    cnt_d       = '0;
                    lock_loss_s = 1'b1;
                end else if (soft_reset_req) begin
                    state_d = SOFT_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            SOFT_RST: begin
                if (!locked_s) begin
                    state_d     = PLL_RST;
                    cnt_d       = '0;
                    lock_loss_s = 1'b1;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = MEM_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and outputs decoded from the next state so they switch on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            stable_q      <= '0;
            pll_rst_q     <= 1'b1;
            mem_reset_n_q <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            seq_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            pll_rst_q     <= (state_d == PLL_RST);
            mem_reset_n_q <= (state_d == MEM_REL) || (state_d == RUN);
            cpu_reset_n_q <= (state_d == RUN);
            seq_ready_q   <= (state_d == RUN);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign mem_reset_n = mem_reset_n_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign seq_ready   = seq_ready_q;

`ifdef RESET_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] lock_loss_cnt_q;
    logic                  lock_timeout_q;

    // Lock-loss event counter and sticky timeout flag, cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_cnt_q <= '0;
            lock_timeout_q  <= 1'b0;
        end else begin
            if (lock_loss_s) begin
                lock_loss_cnt_q <= sat_inc(lock_loss_cnt_q);
            end else begin
                lock_loss_cnt_q <= lock_loss_cnt_q;
            end
            lock_timeout_q <= lock_timeout_q | timeout_s;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
    assign lock_timeout  = lock_timeout_q;
`else
    logic status_unused_s;
    assign status_unused_s = lock_loss_s ^ timeout_s;
`endif

endmodule

// File: tb/tb_nios_system_reset_seq.sv
// Directed scoreboard bench for nios_system_reset_seq (small parameter set).
module tb_nios_system_reset_seq;
    import nios_system_rst_pkg::*;

    localparam logic [3:0] O_RST  = 4'b1000;
    localparam logic [3:0] O_WAIT = 4'b0000;
    localparam logic [3:0] O_MEM  = 4'b0100;
    localparam logic [3:0] O_RUN  = 4'b0111;
    localparam logic [3:0] O_SOFT = 4'b0000;

    logic clk = 1'b0;
    logic reset_n, pll_locked, soft_reset_req;
    logic pll_rst, mem_reset_n, cpu_reset_n, seq_ready;
    logic [3:0] obs_s;
`ifdef RESET_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;
    logic                  lock_timeout;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    assign obs_s = {pll_rst, mem_reset_n, cpu_reset_n, seq_ready};

    nios_system_reset_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .STAGE_CYCLES        (4),
        .SYNC_STAGES         (2),
        .CNT_W               (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .mem_reset_n    (mem_reset_n),
        .cpu_reset_n    (cpu_reset_n),
        .seq_ready      (seq_ready)
`ifdef RESET_SEQ_STATUS_EN
        ,
        .lock_loss_cnt  (lock_loss_cnt),
        .lock_timeout   (lock_timeout)
`endif
    );

    task automatic check_outputs();
        logic [3:0] exp_v;
        string      tag_v;
        exp_v = exp_q.pop_front();
        tag_v = tag_q.pop_front();
        checks++;
        assert (obs_s === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (pll_rst,mem_n,cpu_n,ready)", tag_v, obs_s, exp_v);
        end
    endtask

    // Expect the same output vector after each of the next n clock edges.
    task automatic run(input int n, input logic [3:0] exp_v, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_v);
            tag_q.push_back(tag);
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    task automatic check_now(input logic [3:0] exp_v, input string tag);
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        #1;
        check_outputs();
    endtask

`ifdef RESET_SEQ_STATUS_EN
    task automatic check_status(input string tag, input logic [7:0] cnt_v, input logic to_v);
        checks++;
        assert ((lock_loss_cnt === cnt_v) && (lock_timeout === to_v)) else begin
            errors++;
            $error("FAIL %s: observed cnt=%0d timeout=%b expected cnt=%0d timeout=%b",
                   tag, lock_loss_cnt, lock_timeout, cnt_v, to_v);
        end
    endtask
`endif

    initial begin
        reset_n        = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        run(3, O_RST, "reset_hold");
`ifdef RESET_SEQ_STATUS_EN
        check_status("reset_status", 8'd0, 1'b0);
`endif

        // Cold boot: pll_rst for 4 cycles, lock applied from cycle 6.
        reset_n = 1'b1;
        run(3, O_RST, "boot_pll_rst");
        run(2, O_WAIT, "boot_pll_rst_end");
        pll_locked = 1'b1;
        run(9, O_WAIT, "boot_qualify");
        run(4, O_MEM, "boot_mem_rel");
        run(3, O_RUN, "boot_run");

        // Soft reset from RUN.
        soft_reset_req = 1'b1;
        run(1, O_SOFT, "soft_enter");
        soft_reset_req = 1'b0;
        run(3, O_SOFT, "soft_hold");
        run(4, O_MEM, "soft_mem_rel");
        run(2, O_RUN, "soft_run");

        // Soft reset pulse during MEM_REL must be ignored.
        soft_reset_req = 1'b1;
        run(1, O_SOFT, "soft2_enter");
        soft_reset_req = 1'b0;
        run(3, O_SOFT, "soft2_hold");
        run(1, O_MEM, "soft2_mem_rel");
        soft_reset_req = 1'b1;
        run(1, O_MEM, "soft_in_mem_ignored");
        soft_reset_req = 1'b0;
        run(2, O_MEM, "soft2_mem_rel_end");
        run(2, O_RUN, "soft2_run");

        // Lock loss in RUN, then lock held low for repeated timeouts.
        pll_locked = 1'b0;
        run(2, O_RUN, "loss_sync_delay");
        run(1, O_RST, "loss_pll_rst");
`ifdef RESET_SEQ_STATUS_EN
        check_status("loss_status", 8'd1, 1'b0);
`endif
        run(3, O_RST, "loss_pll_rst_hold");
        run(32, O_WAIT, "timeout1_wait");
        run(1, O_RST, "timeout1_pll_rst");
`ifdef RESET_SEQ_STATUS_EN
        check_status("timeout_status", 8'd1, 1'b1);
`endif
        run(3, O_RST, "timeout1_pll_rst_hold");
        run(32, O_WAIT, "timeout2_wait");
        run(4, O_RST, "timeout2_pll_rst");

        // Glitchy lock: 5 good, 1 bad, then steady; release needs 8 unbroken cycles.
        pll_locked = 1'b1;
        run(5, O_WAIT, "glitch_first_run");
        pll_locked = 1'b0;
        run(1, O_WAIT, "glitch_drop");
        pll_locked = 1'b1;
        run(9, O_WAIT, "glitch_requalify");
        run(2, O_MEM, "glitch_mem_rel");

        // Asynchronous reset in MEM_REL takes effect with no clock edge.
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        check_now(O_RST, "async_reset");
`ifdef RESET_SEQ_STATUS_EN
        check_status("async_reset_status", 8'd0, 1'b0);
`endif
        run(2, O_RST, "async_reset_hold");

        // Lock qualification completes on the same edge as the timeout.
        reset_n = 1'b1;
        run(3, O_RST, "tie_pll_rst");
        run(23, O_WAIT, "tie_wait_unlocked");
        pll_locked = 1'b1;
        run(9, O_WAIT, "tie_wait_locked");
        run(1, O_MEM, "tie_mem_wins");
`ifdef RESET_SEQ_STATUS_EN
        check_status("tie_status", 8'd0, 1'b0);
`endif
        run(3, O_MEM, "tie_mem_rel");
        run(1, O_RUN, "tie_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
